// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder: request side drives start and
// the operands, the adder returns busy/done and the registered result.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell fed LSB first with a registered
// carry loop; {cout, sum} = a + b + cin appears with a one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for start; sum/cout hold the last result
// ADD   | one bit pair per edge through the full_adder, WIDTH edges total

module full_adder (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic s,
    output logic c
);
    assign s = x ^ y ^ z;
    assign c = (x & y) | (z & (x ^ y));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, ADD} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_q;
    logic             carry_q, cout_q, done_q;
    logic [CW-1:0]    cnt;
    logic             load, step, last;
    logic             fa_s, fa_c;

    full_adder u_fa (
        .x (a_sh[0]),
        .y (b_sh[0]),
        .z (carry_q),
        .s (fa_s),
        .c (fa_c)
    );

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load       = 1'b1;
                    state_next = ADD;
                end
            end
            ADD: begin
                step = 1'b1;
                if (cnt == CW'(WIDTH - 1)) begin
                    last       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh    <= '0;
            b_sh    <= '0;
            sum_sh  <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= last;
            if (load) begin
                a_sh    <= bus.a;
                b_sh    <= bus.b;
                sum_sh  <= '0;
                carry_q <= bus.cin;
                cnt     <= '0;
            end else if (step) begin
                a_sh    <= a_sh >> 1;
                b_sh    <= b_sh >> 1;
                sum_sh  <= {fa_s, sum_sh[WIDTH-1:1]};
                carry_q <= fa_c;
                cnt     <= cnt + CW'(1);
                // The final bit lands straight in the result register, so sum
                // is complete on the same edge that raises done.
                if (last) begin
                    sum_q  <= {fa_s, sum_sh[WIDTH-1:1]};
                    cout_q <= fa_c;
                end
            end
        end
    end

    assign bus.busy = (state == ADD);
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Randomized and directed checks of serial_adder at WIDTH=8 and an exhaustive
// WIDTH=4 sweep, using a cycle-level reference model plus a result scoreboard.
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst8, rst4;
    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8)) bus8 ();
    serial_adder_if #(.WIDTH(4)) bus4 ();

    serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst8), .bus(bus8.slave));
    serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst4), .bus(bus4.slave));

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: idle/busy countdown and the arithmetic sum, per DUT.
    int         m8_cnt = 0, m4_cnt = 0;
    bit         m8_done = 0, m4_done = 0, m4_acc = 0;
    logic [8:0] m8_res = '0, m8_pend = '0;
    logic [4:0] m4_res = '0, m4_pend = '0;
    logic [8:0] q8[$];
    logic [4:0] q4[$];
    int         n4_done = 0;
    bit         ex_done = 0;

    always @(posedge clk) begin
        if (rst8) begin
            m8_cnt = 0; m8_done = 0; m8_res = '0; q8.delete();
        end else begin
            m8_done = 0;
            if (m8_cnt > 0) begin
                m8_cnt--;
                if (m8_cnt == 0) begin m8_done = 1; m8_res = m8_pend; end
            end else if (bus8.start) begin
                m8_cnt  = 8;
                m8_pend = 9'(bus8.a) + 9'(bus8.b) + 9'(bus8.cin);
                q8.push_back(m8_pend);
            end
        end
    end

    always @(posedge clk) begin
        if (rst4) begin
            m4_cnt = 0; m4_done = 0; m4_acc = 0; m4_res = '0; q4.delete();
        end else begin
            m4_done = 0;
            m4_acc  = 0;
            if (m4_cnt > 0) begin
                m4_cnt--;
                if (m4_cnt == 0) begin m4_done = 1; m4_res = m4_pend; end
            end else if (bus4.start) begin
                m4_cnt  = 4;
                m4_acc  = 1;
                m4_pend = 5'(bus4.a) + 5'(bus4.b) + 5'(bus4.cin);
                q4.push_back(m4_pend);
            end
        end
    end

    // Monitor: compare every cycle, pop the scoreboard on each done pulse.
    always @(negedge clk) begin
        check("busy8", bus8.busy, m8_cnt > 0);
        check("done8", bus8.done, m8_done);
        check("result8", {bus8.cout, bus8.sum}, m8_res);
        if (bus8.done) begin
            if (q8.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb8: done with no pending operation at %0t", $time);
            end else begin
                check("sb8", {bus8.cout, bus8.sum}, q8.pop_front());
            end
        end
        check("busy4", bus4.busy, m4_cnt > 0);
        check("done4", bus4.done, m4_done);
        check("result4", {bus4.cout, bus4.sum}, m4_res);
        if (bus4.done) begin
            n4_done++;
            if (q4.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb4: done with no pending operation at %0t", $time);
            end else begin
                check("sb4", {bus4.cout, bus4.sum}, q4.pop_front());
            end
        end
    end

    task automatic wait_idle8();
        for (int i = 0; i < 20 && m8_cnt != 0; i++) begin
            @(posedge clk); #1;
        end
        check("idle8_timeout", m8_cnt, 0);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin);
        bus8.a = a; bus8.b = b; bus8.cin = cin; bus8.start = 1'b1;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        wait_idle8();
    endtask

    // Exhaustive WIDTH=4 sweep with start held high: advance on each acceptance.
    initial begin
        int idx, guard;
        bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        idx = 0; guard = 0;
        bus4.a = 4'(idx); bus4.b = 4'(idx >> 4); bus4.cin = 1'(idx >> 8);
        bus4.start = 1'b1;
        while (idx < 512 && guard < 4000) begin
            @(posedge clk); #1;
            guard++;
            if (m4_acc) idx++;
            bus4.a = 4'(idx); bus4.b = 4'(idx >> 4); bus4.cin = 1'(idx >> 8);
        end
        bus4.start = 1'b0;
        check("ex4_all_issued", idx, 512);
        repeat (8) @(posedge clk);
        ex_done = 1;
    end

    initial begin
        rst8 = 1'b1; rst4 = 1'b1;
        bus8.start = 1'b1; bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.cin = 1'b1;
        repeat (2) @(posedge clk); #1;
        rst8 = 1'b0; rst4 = 1'b0; bus8.start = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("no_start_after_reset", bus8.busy, 0);

        op8(8'h35, 8'h4A, 1'b0);
        check("basic_35_4A", {bus8.cout, bus8.sum}, 9'h07F);
        op8(8'hFF, 8'h01, 1'b0);
        check("carry_FF_01", {bus8.cout, bus8.sum}, 9'h100);
        op8(8'hFF, 8'hFF, 1'b1);
        check("carry_FF_FF_1", {bus8.cout, bus8.sum}, 9'h1FF);

        // Held start with operands scrambled every cycle.
        bus8.a = 8'h10; bus8.b = 8'h20; bus8.cin = 1'b0; bus8.start = 1'b1;
        @(posedge clk); #1;
        for (int i = 1; i <= 18; i++) begin
            bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.cin = 1'($urandom);
            @(posedge clk); #1;
            if (i == 8) begin
                check("held_first_done", bus8.done, 1);
                check("held_first_sum", {bus8.cout, bus8.sum}, 9'h030);
            end
            if (i == 9)  check("held_reaccept_busy", bus8.busy, 1);
            if (i == 16) check("held_second_not_yet", bus8.done, 0);
            if (i == 17) check("held_second_done", bus8.done, 1);
        end
        bus8.start = 1'b0;
        wait_idle8();

        // Reset on the 4th ADD edge aborts without a done pulse.
        bus8.a = 8'h0F; bus8.b = 8'h01; bus8.cin = 1'b0; bus8.start = 1'b1;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst8 = 1'b1;
        @(posedge clk); #1;
        rst8 = 1'b0;
        check("abort_busy", bus8.busy, 0);
        check("abort_result", {bus8.cout, bus8.sum}, 9'h000);
        repeat (10) @(posedge clk); #1;
        check("abort_no_done", bus8.done, 0);
        op8(8'h0F, 8'h01, 1'b0);
        check("after_abort", {bus8.cout, bus8.sum}, 9'h010);

        // Random traffic with random gaps; some starts land while busy.
        for (int n = 0; n < 40; n++) begin
            bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.cin = 1'($urandom);
            bus8.start = 1'b1;
            @(posedge clk); #1;
            bus8.start = 1'b0;
            repeat ($urandom_range(0, 12)) @(posedge clk);
            #1;
        end
        wait_idle8();
        repeat (2) @(posedge clk); #1;

        for (int i = 0; i < 6000 && !ex_done; i++) @(posedge clk);
        #1;
        check("ex4_finished", ex_done, 1);
        check("ex4_done_count", n4_done, 512);
        check("sb8_drained", q8.size(), 0);
        check("sb4_drained", q4.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder built around a single instance of the team's existing `full_adder` cell (ports x, y, z, s, c). It captures two operands and a carry-in on a start strobe, then feeds the cell one bit pair per clock, LSB first, with a registered carry loop. It presents {cout, sum} = a + b + cin with a done pulse. It is the sequencing stage directly upstream of `full_adder`, trading WIDTH cycles of latency for one adder cell.

## Interface
- WIDTH, default 8: operand and sum width in bits; legal range WIDTH >= 2.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request; sampled only while idle.
- a  input  WIDTH  operand A, captured on the accepting edge.
- b  input  WIDTH  operand B, captured on the accepting edge.
- cin  input  1  carry-in, captured on the accepting edge.
- busy  output  1  high while a bit-serial addition is in progress.
- done  output  1  one-cycle pulse: sum/cout just updated.
- sum  output  WIDTH  registered result, low WIDTH bits of a+b+cin.
- cout  output  1  registered carry out of bit WIDTH-1.

## Operation
- States: IDLE, ADD. The done pulse is a registered flag, not a state.
- IDLE, start=1 at edge E0: load the a/b shift registers and carry_q<=cin, clear bit counter, enter ADD; busy=1.
- IDLE, start=0: hold. sum/cout keep their last result.
- ADD, each edge:
  - Drive the full_adder with x=a_sh[0], y=b_sh[0], z=carry_q.
  - Shift s into sum_sh at the MSB end. Capture carry_q<=c.
  - Shift a_sh and b_sh right by one. Increment the counter.
- On the WIDTH-th ADD edge:
  - sum<=final sum_sh including this bit; cout<=c.
  - done<=1, busy<=0, return to IDLE.
- done clears on the following edge unless that edge itself completes another operation, which cannot happen for WIDTH >= 2.
- start while busy=1 is ignored; no queuing.
- start during the done cycle is accepted because the block is idle (back-to-back operation).
- a, b, cin are don't-care outside the accepting edge. Changes during ADD have no effect.
- Arithmetic: {cout, sum} = a + b + cin, modulo 2^(WIDTH+1). No overflow flag. The counter is $clog2(WIDTH+1) bits wide.
- rst=1 at any edge, including mid-ADD and coincident with start:
  - State returns to IDLE; busy=0, done=0, sum=0, cout=0.
  - Shift registers, carry_q and counter clear.
  - Reset has priority over start. An aborted operation never produces done.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0.
- Accepting edge E0: busy=1 in the cycles after E0 through E(WIDTH-1), i.e. exactly WIDTH cycles.
- Edges E1..E(WIDTH) process bits 0..WIDTH-1.
- After E(WIDTH): done=1 for exactly one cycle, busy=0, sum/cout valid and stable until the next completion or reset.
- Latency from start to done is WIDTH edges. Maximum throughput is one operation per WIDTH+1 cycles.
- busy and done are never high in the same cycle.

## Test plan
- Reset: assert rst for 2 cycles with start=1, a=8'hFF, b=8'hFF. Required: busy=0, done=0, sum=8'h00, cout=0 during and after reset, and no operation starts.
- Basic add, WIDTH=8: a=8'h35, b=8'h4A, cin=0, start for 1 cycle. Required: busy high for exactly 8 cycles, done pulses 8 edges after E0, sum=8'h7F, cout=0.
- Carry chain: a=8'hFF, b=8'h01, cin=0 gives sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 gives sum=8'hFF, cout=1.
- Held start / operand changes:
  - Stimulus: start held high continuously; a=8'h10, b=8'h20 at E0, then a/b changed every cycle.
  - Required: the first done shows sum=8'h30, and start is ignored while busy.
  - Required: the second operation is accepted at E9 with done after E17, giving period 9.
- Reset mid-operation: start a=8'h0F, b=8'h01, then assert rst on the 4th ADD edge. Required: busy=0 from the next cycle, no done pulse, sum=0, cout=0. A fresh start afterwards completes correctly.
- Exhaustive, WIDTH=4: all 512 combinations of a, b, cin issued back-to-back. Required: every {cout, sum} matches a+b+cin, and done is never missed or doubled.
